// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared state encoding and reset defaults for the SD clock generator
package sd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } sd_state_e;

  // 500-cycle half period after reset gives a 1000-cycle SD clock period
  localparam int SD_DEFAULT_HALF = 500;

endpackage

// File: rtl/sd_clock_gen.sv
// rtl/sd_clock_gen.sv - programmable 50% duty SD clock divider with edge strobes
module sd_clock_gen
  import sd_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int RESET_HALF = SD_DEFAULT_HALF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] half_in,
  input  logic             half_load,
  output logic             out_clk,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             running,
  output logic [CNT_W-1:0] half_cur
);

  localparam logic [CNT_W-1:0] RESET_VAL = CNT_W'(RESET_HALF);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  sd_state_e        state;
  sd_state_e        state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] pending;
  logic             pend_valid;
  logic [CNT_W-1:0] half_clamped;
  logic [CNT_W-1:0] load_val;
  logic             load_valid;
  logic             phase_end;
  logic             enter_low;

  assign half_clamped = (half_in == '0) ? ONE : half_in;
  // A load on the boundary cycle itself wins over anything already pending
  assign load_val     = half_load ? half_clamped : pending;
  assign load_valid   = half_load | pend_valid;
  assign phase_end    = (count == half_cur - ONE);
  assign running      = (state != ST_IDLE);
  assign enter_low    = (state_nxt == ST_LOW) && (state != ST_LOW);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (en)        state_nxt = ST_LOW;
      ST_LOW:  if (phase_end) state_nxt = en ? ST_HIGH : ST_IDLE;
      ST_HIGH: if (phase_end) state_nxt = en ? ST_LOW : ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      out_clk    <= 1'b0;
      rise_stb   <= 1'b0;
      fall_stb   <= 1'b0;
      half_cur   <= RESET_VAL;
      pending    <= RESET_VAL;
      pend_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      out_clk  <= (state_nxt == ST_HIGH);
      rise_stb <= (state == ST_LOW) && (state_nxt == ST_HIGH);
      fall_stb <= (state == ST_HIGH) && (state_nxt != ST_HIGH);

      if (state_nxt != state)
        count <= '0;
      else if (state != ST_IDLE)
        count <= count + ONE;

      // Divisor changes only take effect at the start of a full period
      if (enter_low) begin
        if (load_valid) half_cur <= load_val;
        pending    <= load_val;
        pend_valid <= 1'b0;
      end else if (half_load) begin
        pending    <= half_clamped;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sd_clock_gen.md
SD_CLOCK_GEN -- requirements
Module: sd_clock_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning width of the half-period counter and half-period value.
REQ-002 SHALL have parameter RESET_HALF, default 500, meaning the half-period in clk cycles after reset (gives a 1000-cycle period).
REQ-003 SHALL have port clk, input, 1 bit, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port en, input, 1 bit, run request for the SD clock.
REQ-006 SHALL have port half_in, input, CNT_W bits, new half-period in clk cycles.
REQ-007 SHALL have port half_load, input, 1 bit, single-cycle strobe that captures half_in.
REQ-008 SHALL have port out_clk, output, 1 bit, registered SD clock, 50% duty.
REQ-009 SHALL have port rise_stb, output, 1 bit, high for exactly the first clk cycle that out_clk is 1 in each high phase.
REQ-010 SHALL have port fall_stb, output, 1 bit, high for exactly the first clk cycle that out_clk is 0 after a high phase.
REQ-011 SHALL have port running, output, 1 bit, 1 whenever state is not IDLE.
REQ-012 SHALL have port half_cur, output, CNT_W bits, half-period currently in effect.

Function
REQ-013 SHALL implement states IDLE, LOW and HIGH, with out_clk = 1 only in HIGH.
REQ-014 SHALL move IDLE -> LOW with count = 0 on a cycle where en = 1, and otherwise stay in IDLE.
REQ-015 SHALL, in LOW and HIGH, increment count each cycle until count == half_cur-1, which is the phase end.
REQ-016 SHALL, at LOW phase end: go to HIGH (count 0, rise_stb next cycle) if en = 1; else go to IDLE with out_clk held 0 and no rising edge.
REQ-017 SHALL, at HIGH phase end: go to LOW (count 0) if en = 1, else go to IDLE; fall_stb pulses in both cases.
REQ-018 SHALL never shorten a high phase; deasserting en mid-HIGH completes the full high phase.
REQ-019 SHALL latch half_in into a pending register on half_load, where a later load before application overwrites the earlier one.
REQ-020 SHALL apply the pending value to half_cur only on entry to LOW (from IDLE or HIGH), so no phase ever has mixed length.
REQ-021 SHALL clamp half_in = 0 to 1 on capture; half = 1 gives out_clk toggling every clk cycle.
REQ-022 SHALL, when half_load and a phase-end boundary coincide, use the newly loaded value for the period starting that boundary.
REQ-023 SHALL use count width CNT_W, with no count wrap possible because the phase end is reached first.

Reset
REQ-024 SHALL, on reset = 1 at a clk edge, set the following regardless of state: state IDLE, count 0, out_clk 0, rise_stb 0, fall_stb 0, running 0, half_cur = RESET_HALF, pending = RESET_HALF, pending-valid 0.
REQ-025 SHALL, when reset is asserted mid-HIGH, drive out_clk low on the next cycle without fall_stb.

Structure
REQ-026 SHALL define the state enum (IDLE/LOW/HIGH) and the default RESET_HALF constant in shared package sd_pkg.
REQ-027 SHALL be a single module with no sub-module (expected 120-250 lines of RTL).

Verification
REQ-028 SHALL verify default period: reset, then en = 1 held -> out_clk low 500 cycles, high 500 cycles, repeating; rise_stb at cycle 501; fall_stb at cycle 1001.
REQ-029 SHALL verify divisor change: half_in = 3 loaded mid-HIGH of a 500 period -> current high completes at 500; next LOW and HIGH are 3 cycles each; half_cur reads 3 from LOW entry.
REQ-030 SHALL verify stop: en dropped 10 cycles into HIGH -> high lasts 500 total, fall_stb once, then IDLE, out_clk 0, running 0.
REQ-031 SHALL verify clamp: half_in = 0 loaded -> half_cur = 1; out_clk toggles each clk; rise_stb and fall_stb alternate every cycle.
REQ-032 SHALL verify reset mid-operation: reset during HIGH at count 200 -> next cycle out_clk 0, half_cur = 500, no strobes.
REQ-033 SHALL verify the coincident case: half_load = 1 (half_in = 4) on a HIGH phase-end cycle with en = 1 -> the following LOW lasts 4 cycles.
